data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache.sv | 198 +++++++++++++++++++
 tb/tb_data_cache.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// data_cache: direct-mapped cache with one-word lines in front of an internal
// backing memory that has a fixed read latency. Stores are write-through and
// write-allocate. Load misses stall for the fetch and then fill the line.
// Optional build macro DATA_CACHE_STATS_EN adds hit_count / miss_count outputs.
module data_cache #(
  parameter int NUM_LINES   = 8,
  parameter int MEM_WORDS   = 1024,
  parameter int MEM_LATENCY = 20
) (
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        memwrite,
  input  logic        clk,
  output logic [31:0] read_data,
  input  logic        rst_n,
  output logic        stall
`ifdef DATA_CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = 32 - IDX_W;
  localparam int WORD_W = $clog2(MEM_WORDS);
  localparam int CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FILL  = 2'd2
  } state_t;

  // Control state
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        miss_addr_q, miss_addr_d;
  logic [31:0]        read_data_q, read_data_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;

  // Line storage (tag and data); validity lives in valid_q so reset clears it.
  logic [TAG_W-1:0]   line_tag_q  [NUM_LINES];
  logic [31:0]        line_data_q [NUM_LINES];
  logic               line_we;
  logic [IDX_W-1:0]   line_idx;
  logic [TAG_W-1:0]   line_tag_wr;
  logic [31:0]        line_data_wr;

  // Backing memory. It is never cleared by reset; its zero contents come from
  // the power-up configuration of the block RAM (and 2-state sim init).
  logic [31:0]        mem_q [MEM_WORDS];
  logic [31:0]        mem_rdata_q;
  logic               mem_we;
  logic [WORD_W-1:0]  mem_waddr;
  logic [WORD_W-1:0]  fill_word;

  // Live request decode
  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               hit;

  assign req_idx   = addr[IDX_W-1:0];
  assign req_tag   = addr[31:IDX_W];
  assign hit       = valid_q[req_idx] && (line_tag_q[req_idx] == req_tag);
  assign fill_word = miss_addr_q[WORD_W-1:0];
  assign read_data = read_data_q;

  // Next-state, line/memory write controls and stall
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    miss_addr_d  = miss_addr_q;
    read_data_d  = read_data_q;
    valid_d      = valid_q;
    stall        = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = addr[WORD_W-1:0];
    line_we      = 1'b0;
    line_idx     = req_idx;
    line_tag_wr  = req_tag;
    line_data_wr = write_data;

    case (state_q)
      IDLE: begin
        if (memwrite) begin
          // Write-through to memory and allocate the line; storage writes are
          // held off while reset is asserted so reset never disturbs memory.
          mem_we          = rst_n;
          line_we         = rst_n;
          valid_d[req_idx] = 1'b1;
        end else if (hit) begin
          read_data_d = line_data_q[req_idx];
        end else begin
          stall       = 1'b1;
          miss_addr_d = addr;
          cnt_d       = '0;
          state_d     = FETCH;
        end
      end

      FETCH: begin
        stall = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = FILL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      FILL: begin
        // mem_rdata_q already holds mem[fill_word]: the latched address has
        // been stable for the whole fetch and no store can intervene.
        stall        = 1'b1;
        line_we      = rst_n;
        line_idx     = miss_addr_q[IDX_W-1:0];
        line_tag_wr  = miss_addr_q[31:IDX_W];
        line_data_wr = mem_rdata_q;
        valid_d[miss_addr_q[IDX_W-1:0]] = 1'b1;
        read_data_d  = mem_rdata_q;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      miss_addr_q <= '0;
      read_data_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      miss_addr_q <= miss_addr_d;
      read_data_q <= read_data_d;
      valid_q     <= valid_d;
    end
  end

  // Line tag/data storage, written by allocating stores and by fills
  always_ff @(posedge clk) begin
    if (line_we) begin
      line_tag_q[line_idx]  <= line_tag_wr;
      line_data_q[line_idx] <= line_data_wr;
    end
  end

  // Backing memory: write port for stores, registered read of the fill word
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= write_data;
    end
    mem_rdata_q <= mem_q[fill_word];
  end

`ifdef DATA_CACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;
  logic        load_idle;

  assign load_idle  = (state_q == IDLE) && !memwrite;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  // Count IDLE load hits and misses; stores leave both counters alone
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (load_idle && hit) begin
      hit_count_d = hit_count_q + 32'd1;
    end
    if (load_idle && !hit) begin
      miss_count_d = miss_count_q + 32'd1;
    end
  end

  // Statistics registers, cleared by reset and free-running modulo 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end
`endif

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: randomized scoreboard bench for data_cache. The driver pushes
// the expected load result and stall length into a queue; a negedge monitor
// pops and compares whenever a load is accepted (stall low on a load).
module tb_data_cache;
  localparam int NL         = 8;
  localparam int MW         = 1024;
  localparam int LAT        = 20;
  localparam int MISS_STALL = LAT + 2;

  logic [31:0] addr, write_data, read_data;
  logic        memwrite, clk, rst_n, stall;
`ifdef DATA_CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  data_cache #(.NUM_LINES(NL), .MEM_WORDS(MW), .MEM_LATENCY(LAT)) dut (
    .addr       (addr),
    .write_data (write_data),
    .memwrite   (memwrite),
    .clk        (clk),
    .read_data  (read_data),
    .rst_n      (rst_n),
    .stall      (stall)
`ifdef DATA_CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] data;
    int          stall_cycles;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdl_mem  [int];   // word number -> stored value (absent = 0)
  logic [31:0] mdl_line [int];   // line index  -> full address resident there
  int unsigned mdl_hits   = 0;
  int unsigned mdl_misses = 0;
  bit          op_live    = 1'b0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    int w;
    w = int'(a % MW);
    return mdl_mem.exists(w) ? mdl_mem[w] : 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Called at posedge+1; the store takes effect at the next rising edge.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    addr       = a;
    write_data = d;
    memwrite   = 1'b1;
    op_live    = 1'b1;
    mdl_mem[int'(a % MW)]  = d;
    mdl_line[int'(a % NL)] = a;
    @(posedge clk);
    #1;
    op_live = 1'b0;
    $display("store addr=%08h data=%08h", a, d);
  endtask

  // Called at posedge+1; holds the load until stall drops, then one more edge.
  task automatic do_load(input logic [31:0] a);
    exp_t e;
    int   idx;
    int   waited;
    bit   is_hit;
    idx    = int'(a % NL);
    is_hit = mdl_line.exists(idx) && ((mdl_line[idx] / NL) == (a / NL));
    e.data         = mem_rd(a);
    e.stall_cycles = is_hit ? 0 : MISS_STALL;
    exp_q.push_back(e);
    // A miss counts once, then the held request hits after the fill.
    if (!is_hit) mdl_misses++;
    mdl_hits++;
    mdl_line[idx] = a;
    addr       = a;
    memwrite   = 1'b0;
    write_data = $urandom;
    op_live    = 1'b1;
    waited     = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (stall !== 1'b0 && waited < MISS_STALL + 10);
    if (stall !== 1'b0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL load_timeout: stall still %b after %0d cycles, expected 0", stall, waited);
    end
    @(posedge clk);
    #1;
    op_live = 1'b0;
    $display("load  addr=%08h %s expect=%08h", a, is_hit ? "hit " : "miss", e.data);
  endtask

  // Monitor: scoreboard pop on each accepted load, stall checks on stores
  int          run = 0;
  bit          pend = 1'b0;
  logic [31:0] pend_data;
  always @(negedge clk) begin
    exp_t e;
    if (pend) begin
      check("load_data", read_data, pend_data);
      pend = 1'b0;
    end
    if (op_live) begin
      if (memwrite) begin
        check("store_stall", {31'b0, stall}, 32'd0);
        run = 0;
      end else if (stall !== 1'b0) begin
        run++;
      end else begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_load: got accepted load, expected none queued");
        end else begin
          e = exp_q.pop_front();
          check("stall_cycles", 32'(run), 32'(e.stall_cycles));
          if (e.stall_cycles > 0) check("fill_data", read_data, e.data);
          pend      = 1'b1;
          pend_data = e.data;
        end
        run = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] hi;
    addr       = 32'h0;
    write_data = 32'h0;
    memwrite   = 1'b1;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_read_data", read_data, 32'h0);
    check("reset_stall", {31'b0, stall}, 32'd0);
`ifdef DATA_CACHE_STATS_EN
    check("reset_hit_count", hit_count, 32'd0);
    check("reset_miss_count", miss_count, 32'd0);
`endif
    rst_n = 1'b1;

    // Directed sequence: cold miss, hit, store/load, conflicts, unwritten word
    do_load(32'd1);
    do_load(32'd1);
    do_store(32'd1, 32'd7);
    do_load(32'd1);
    do_store(32'd32, 32'd3);
    do_load(32'd32);
    do_load(32'd1);
    do_store(32'd8, 32'd5);
    do_load(32'd32);
    do_load(32'd36);
    do_load(32'd1);

    // Reset in the middle of a fetch: fill is aborted, memory survives
    addr     = 32'h4000_0001;
    memwrite = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("fetch_stall", {31'b0, stall}, 32'd1);
    rst_n      = 1'b0;
    memwrite   = 1'b1;
    addr       = 32'd1;
    write_data = mem_rd(32'd1);
    #1;
    check("abort_stall", {31'b0, stall}, 32'd0);
    check("abort_read_data", read_data, 32'h0);
`ifdef DATA_CACHE_STATS_EN
    check("abort_hit_count", hit_count, 32'd0);
    check("abort_miss_count", miss_count, 32'd0);
`endif
    mdl_line.delete();
    mdl_hits   = 0;
    mdl_misses = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_load(32'd1);

    // Randomized phase: small address pool with aliasing tags and wrap-around
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0:       hi = 32'h0000_0400;
        1:       hi = 32'h8000_0000;
        default: hi = 32'h0;
      endcase
      a = hi | 32'($urandom_range(0, 47));
      if ($urandom_range(0, 9) < 4) do_store(a, $urandom);
      else                          do_load(a);
    end

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef DATA_CACHE_STATS_EN
    check("final_hit_count", hit_count, 32'(mdl_hits));
    check("final_miss_count", miss_count, 32'(mdl_misses));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
